// File: rtl/trip_supervisor.sv
// rtl/trip_supervisor.sv - multi-source trip aggregator producing a registered PWM run enable
// Optional TRIP_SUP_COUNT_EN adds a saturating count of entries into FAULT.
module trip_supervisor #(
  parameter int                N_SRC        = 8,
  parameter logic [N_SRC-1:0]  ACT_LOW_MASK = '0,
  parameter int                DEBOUNCE_CYC = 4,
  parameter int                ARM_CYC      = 64,
  localparam int               IDX_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk_ctrl_i,
  input  logic             rst_n_i,
  input  logic [N_SRC-1:0] trip_raw_i,
  input  logic [N_SRC-1:0] trip_mask_i,
  input  logic             sw_enable_i,
  input  logic             sw_clear_fault_i,
  output logic             run_en_o,
  output logic             fault_latched_o,
  output logic [N_SRC-1:0] fault_cause_o,
  output logic [IDX_W-1:0] first_fault_idx_o,
  output logic             first_fault_vld_o,
  output logic [1:0]       sup_state_o,
  output logic [15:0]      trip_count_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMING = 2'd1,
    S_RUN    = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam logic [7:0]  DB_LIMIT   = 8'(DEBOUNCE_CYC);
  localparam logic [15:0] ARM_RELOAD = 16'(ARM_CYC - 1);

  (* ASYNC_REG = "TRUE" *) logic [N_SRC-1:0] sync1_q;
  (* ASYNC_REG = "TRUE" *) logic [N_SRC-1:0] sync2_q;

  logic [N_SRC-1:0] norm;
  logic [7:0]       cnt_q [N_SRC];
  logic [7:0]       cnt_d [N_SRC];
  logic [N_SRC-1:0] qual_q, qual_d;
  logic             any_qual;

  state_t           state_q, state_d;
  logic [15:0]      arm_q, arm_d;
  logic             clr_q;
  logic             clr_edge;
  logic             run_en_q;
  logic [N_SRC-1:0] cause_q, cause_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] lowest_idx;
  logic             enter_fault;

  // Masking is applied after the synchroniser so a masked source drops its debounce next cycle.
  assign norm     = (sync2_q ^ ACT_LOW_MASK) & ~trip_mask_i;
  assign any_qual = |qual_q;
  assign clr_edge = sw_clear_fault_i & ~clr_q;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      if (!norm[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] < DB_LIMIT) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      qual_d[i] = norm[i] && (cnt_d[i] >= DB_LIMIT);
    end
  end

  always_ff @(posedge clk_ctrl_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      qual_q  <= '0;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= 8'd0;
    end else begin
      sync1_q <= trip_raw_i;
      sync2_q <= sync1_q;
      qual_q  <= qual_d;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    lowest_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (qual_q[i]) lowest_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_qual) begin
          state_d = S_FAULT;
        end else if (sw_enable_i) begin
          state_d = S_ARMING;
          arm_d   = ARM_RELOAD;
        end
      end
      S_ARMING: begin
        if (any_qual)          state_d = S_FAULT;
        else if (!sw_enable_i) state_d = S_IDLE;
        else if (arm_q == 16'd0) state_d = S_RUN;
        else                   arm_d   = arm_q - 16'd1;
      end
      S_RUN: begin
        if (any_qual)          state_d = S_FAULT;
        else if (!sw_enable_i) state_d = S_IDLE;
      end
      S_FAULT: begin
        // A clear is honoured only once every qualified source has gone away.
        if (clr_edge && !any_qual) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_fault = (state_d == S_FAULT) && (state_q != S_FAULT);

  always_comb begin
    cause_d = cause_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    if (state_d == S_FAULT) begin
      cause_d = cause_q | qual_q;
      if (enter_fault) begin
        idx_d = lowest_idx;
        vld_d = 1'b1;
      end
    end else if (state_q == S_FAULT) begin
      cause_d = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_ctrl_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      arm_q    <= 16'd0;
      clr_q    <= 1'b0;
      run_en_q <= 1'b0;
      cause_q  <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      clr_q    <= sw_clear_fault_i;
      run_en_q <= (state_d == S_RUN);
      cause_q  <= cause_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
    end
  end

`ifdef TRIP_SUP_COUNT_EN
  logic [15:0] trip_cnt_q;

  always_ff @(posedge clk_ctrl_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trip_cnt_q <= 16'd0;
    end else if (enter_fault && (trip_cnt_q != 16'hFFFF)) begin
      trip_cnt_q <= trip_cnt_q + 16'd1;
    end
  end

  assign trip_count_o = trip_cnt_q;
`else
  assign trip_count_o = 16'h0000;
`endif

  assign run_en_o          = run_en_q;
  assign fault_latched_o   = (state_q == S_FAULT);
  assign fault_cause_o     = cause_q;
  assign first_fault_idx_o = idx_q;
  assign first_fault_vld_o = vld_q;
  assign sup_state_o       = state_q;

endmodule

// File: tb/tb_trip_supervisor.sv
// tb/tb_trip_supervisor.sv - directed self-checking bench for trip_supervisor
module tb_trip_supervisor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  trip_raw;
  logic [7:0]  trip_mask;
  logic        sw_enable;
  logic        sw_clear;
  logic        run_en;
  logic        fault_latched;
  logic [7:0]  fault_cause;
  logic [2:0]  ff_idx;
  logic        ff_vld;
  logic [1:0]  sup_state;
  logic [15:0] trip_count;

  int checks   = 0;
  int failures = 0;
  int exp_count;

  always #5 clk = ~clk;

  trip_supervisor #(
    .N_SRC(8), .ACT_LOW_MASK(8'h01), .DEBOUNCE_CYC(4), .ARM_CYC(64)
  ) dut (
    .clk_ctrl_i(clk),
    .rst_n_i(rst_n),
    .trip_raw_i(trip_raw),
    .trip_mask_i(trip_mask),
    .sw_enable_i(sw_enable),
    .sw_clear_fault_i(sw_clear),
    .run_en_o(run_en),
    .fault_latched_o(fault_latched),
    .fault_cause_o(fault_cause),
    .first_fault_idx_o(ff_idx),
    .first_fault_vld_o(ff_vld),
    .sup_state_o(sup_state),
    .trip_count_o(trip_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_count = 0;
    rst_n     = 1'b0;
    trip_raw  = 8'h01;
    trip_mask = 8'h00;
    sw_enable = 1'b0;
    sw_clear  = 1'b0;
    step(3);
    chk("rst_state", sup_state, 0);
    chk("rst_run_en", run_en, 0);
    chk("rst_fault", fault_latched, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_idx", ff_idx, 0);
    chk("rst_vld", ff_vld, 0);
    chk("rst_count", trip_count, 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_no_en", sup_state, 0);

    // T1 arming holdoff: RUN exactly 65 edges after enable is seen
    sw_enable = 1'b1;
    step(1);
    chk("t1_arming", sup_state, 1);
    step(63);
    chk("t1_run_en_e64", run_en, 0);
    step(1);
    chk("t1_run_en_e65", run_en, 1);
    chk("t1_state_run", sup_state, 2);

    // T2 held trip on source 3: run_en drops at edge 7
    trip_raw = 8'h09;
    step(6);
    chk("t2_run_en_e6", run_en, 1);
    step(1);
    chk("t2_run_en_e7", run_en, 0);
    chk("t2_state", sup_state, 3);
    chk("t2_fault", fault_latched, 1);
    chk("t2_idx", ff_idx, 3);
    chk("t2_vld", ff_vld, 1);
    chk("t2_cause", fault_cause, 8'h08);
    exp_count++;
    trip_raw = 8'h01;
    step(4);
    sw_clear = 1'b1;
    step(1);
    chk("t2_clr_idle", sup_state, 0);
    chk("t2_clr_cause", fault_cause, 0);
    chk("t2_clr_vld", ff_vld, 0);
    sw_clear = 1'b0;
    step(1);
    chk("t2_rearm", sup_state, 1);
    step(64);
    chk("t2_back_run", run_en, 1);
    chk("t2_count", trip_count, `ifdef TRIP_SUP_COUNT_EN exp_count `else 0 `endif);

    // T3 debounce: 3-cycle pulse filtered, 5-cycle pulse trips
    trip_raw = 8'h03;
    step(3);
    trip_raw = 8'h01;
    step(8);
    chk("t3_short_run", run_en, 1);
    chk("t3_short_state", sup_state, 2);
    trip_raw = 8'h03;
    step(5);
    trip_raw = 8'h01;
    step(2);
    chk("t3_long_state", sup_state, 3);
    chk("t3_long_run_en", run_en, 0);
    chk("t3_idx", ff_idx, 1);
    chk("t3_cause", fault_cause, 8'h02);
    exp_count++;
    sw_enable = 1'b0;
    step(3);
    sw_clear = 1'b1;
    step(1);
    sw_clear = 1'b0;
    chk("t3_clr_idle", sup_state, 0);

    // T4 simultaneous sources, clear blocked while a source is still held
    trip_raw = 8'h25;
    step(7);
    chk("t4_state", sup_state, 3);
    chk("t4_idx", ff_idx, 2);
    chk("t4_cause", fault_cause, 8'h24);
    exp_count++;
    trip_raw = 8'h05;
    step(4);
    sw_clear = 1'b1;
    step(1);
    chk("t4_clr_blocked", sup_state, 3);
    chk("t4_cause_kept", fault_cause, 8'h24);
    sw_clear = 1'b0;
    step(1);
    trip_raw  = 8'h01;
    sw_enable = 1'b1;
    step(4);
    chk("t4_still_fault", sup_state, 3);
    sw_clear = 1'b1;
    step(1);
    chk("t4_clr_idle", sup_state, 0);
    chk("t4_clr_cause", fault_cause, 0);
    chk("t4_clr_vld", ff_vld, 0);
    chk("t4_clr_idx", ff_idx, 0);
    sw_clear = 1'b0;
    step(1);
    chk("t4_rearm", sup_state, 1);
    sw_enable = 1'b0;
    step(1);
    chk("t4_drop_en", sup_state, 0);

    // T5 active-low source 0 held asserted under mask, then unmasked
    trip_mask = 8'h01;
    trip_raw  = 8'h00;
    step(10);
    chk("t5_masked", sup_state, 0);
    trip_mask = 8'h00;
    step(4);
    chk("t5_unmask_e4", sup_state, 0);
    step(1);
    chk("t5_unmask_e5", sup_state, 3);
    chk("t5_idx", ff_idx, 0);
    chk("t5_vld", ff_vld, 1);
    chk("t5_cause", fault_cause, 8'h01);
    exp_count++;
    trip_raw = 8'h01;
    step(4);
    sw_clear = 1'b1;
    step(1);
    sw_clear = 1'b0;
    chk("t5_clr_idle", sup_state, 0);

    // T6 trip counter, then async reset while running
    chk("t6_count", trip_count, `ifdef TRIP_SUP_COUNT_EN exp_count `else 0 `endif);
    sw_enable = 1'b1;
    step(66);
    chk("t6_pre_rst_run", run_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_run_en", run_en, 0);
    chk("t6_async_state", sup_state, 0);
    chk("t6_async_count", trip_count, 0);
    step(1);
    rst_n = 1'b1;
    sw_enable = 1'b0;
    step(2);
    chk("t6_post_idle", sup_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
